// File: rtl/io_pmp.sv
// I/O PMP checker: SID->memory-domain mapping plus PMP-style entries gate DMA traffic.
// Configuration through a simple register port; denied accesses are captured in RCD.
package iopmp_pkg;
    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_EXEC  = 2'd3
    } iopmp_access_t;
endpackage

module io_pmp #(
    parameter int unsigned PLEN              = 56,
    parameter int unsigned IOPMP_LEN         = 54,
    parameter int unsigned NR_MD             = 2,
    parameter int unsigned NR_ENTRIES_PER_MD = 8,
    parameter int unsigned NR_MASTERS        = 2,
    parameter int unsigned AXI_ADDR_WIDTH    = 32,
    parameter int unsigned AXI_DATA_WIDTH    = 64,
    parameter int unsigned AXI_ID_WIDTH      = 10,
    parameter logic [31:0] IOPMP_BASE        = 32'h5000_0000,
    localparam int unsigned SW = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [PLEN-1:0]           addr_i,
    input  logic [SW-1:0]             sid_i,
    input  logic [1:0]                access_type_i,
    input  logic [63:0]               data_i,
    output logic                      allow_transaction_o,
    input  logic [AXI_ADDR_WIDTH-1:0] address_cfg,
    input  logic                      en_cfg,
    input  logic                      we_cfg,
    input  logic [AXI_DATA_WIDTH-1:0] wdata_cfg,
    output logic [AXI_DATA_WIDTH-1:0] rdata_cfg
);
    import iopmp_pkg::*;

    localparam int unsigned NR_E = NR_MD * NR_ENTRIES_PER_MD;

    function automatic logic [AXI_ADDR_WIDTH-1:0] reg_off(int unsigned base, int unsigned idx,
                                                         int unsigned stride);
        return AXI_ADDR_WIDTH'(base + idx * stride);
    endfunction

    localparam logic [AXI_ADDR_WIDTH-1:0] OFF_CTL    = AXI_ADDR_WIDTH'(32'h000);
    localparam logic [AXI_ADDR_WIDTH-1:0] OFF_RCD    = AXI_ADDR_WIDTH'(32'h008);
    localparam logic [AXI_ADDR_WIDTH-1:0] OFF_MDMASK = AXI_ADDR_WIDTH'(32'h010);

    logic                  r_ctl_l;
    logic                  r_ctl_rcall;
    logic                  r_ctl_en;
    logic [31:0]           r_rcd;
    logic                  r_mdmask_l;
    logic [NR_MD-1:0]      r_mdmask;
    logic                  r_srcmd_l [NR_MASTERS];
    logic [NR_MD-1:0]      r_srcmd   [NR_MASTERS];
    logic [IOPMP_LEN-1:0]  r_addr    [NR_E];
    logic [7:0]            r_cfg     [NR_E];

    logic [AXI_ADDR_WIDTH-1:0] w_off;
    logic                      w_wr;
    logic                      w_rd;
    iopmp_access_t             w_acc;
    logic [IOPMP_LEN-1:0]      w_word;
    logic                      w_sid_ok;
    logic [NR_MD-1:0]          w_sid_md;
    logic [NR_MD-1:0]          w_frozen;
    logic [NR_E-1:0]           w_cand;
    logic [NR_E-1:0]           w_match;
    logic [NR_E-1:0]           w_perm;
    logic [NR_E-1:0]           w_hit;
    logic [NR_E-1:0]           w_first;
    logic                      w_scan_allow;
    logic                      w_record;
    logic                      w_unused;

    assign w_off    = address_cfg - AXI_ADDR_WIDTH'(IOPMP_BASE);
    assign w_wr     = en_cfg & we_cfg;
    assign w_rd     = en_cfg & ~we_cfg;
    assign w_acc    = iopmp_access_t'(access_type_i);
    assign w_word   = addr_i[PLEN-1:2];
    assign w_frozen = {NR_MD{r_mdmask_l}} & r_mdmask;
    assign w_unused = ^{data_i, addr_i[1:0], wdata_cfg, AXI_ID_WIDTH != 0};

    always_comb begin
        w_sid_ok = 1'b0;
        w_sid_md = '0;
        for (int unsigned s = 0; s < NR_MASTERS; s++) begin
            if (sid_i == SW'(s)) begin
                w_sid_ok = 1'b1;
                w_sid_md = r_srcmd[s];
            end
        end
    end

    for (genvar e = 0; e < NR_E; e++) begin : g_entry
        logic [IOPMP_LEN-1:0] w_lo;
        logic [IOPMP_LEN-1:0] w_care;
        if (e == 0) begin : g_first
            assign w_lo = '0;
        end else begin : g_prev
            assign w_lo = r_addr[e-1];
        end
        // NAPOT: the trailing-ones run plus the bit above it are don't-care positions
        assign w_care     = ~(r_addr[e] ^ (r_addr[e] + 1'b1));
        assign w_match[e] = (r_cfg[e][4:3] == 2'b01) ? ((w_word >= w_lo) && (w_word < r_addr[e])) :
                            (r_cfg[e][4:3] == 2'b10) ? (w_word == r_addr[e]) :
                            (r_cfg[e][4:3] == 2'b11) ? (((w_word ^ r_addr[e]) & w_care) == '0) :
                            1'b0;
        assign w_cand[e]  = w_sid_md[e / NR_ENTRIES_PER_MD];
        assign w_perm[e]  = (w_acc == ACC_READ)  ? r_cfg[e][0] :
                            (w_acc == ACC_WRITE) ? r_cfg[e][1] :
                            (w_acc == ACC_EXEC)  ? r_cfg[e][2] : 1'b0;
    end

    // Lowest-index matching candidate wins: isolate the least significant set bit
    assign w_hit        = w_cand & w_match;
    assign w_first      = w_hit & (~w_hit + NR_E'(1));
    assign w_scan_allow = |(w_first & w_perm);

    always_comb begin
        if (!r_ctl_en)
            allow_transaction_o = 1'b1;
        else if (w_acc == ACC_NONE || !w_sid_ok)
            allow_transaction_o = 1'b0;
        else
            allow_transaction_o = w_scan_allow;
    end

    assign w_record = r_ctl_en && (w_acc != ACC_NONE) && !allow_transaction_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctl_l     <= 1'b0;
            r_ctl_rcall <= 1'b0;
            r_ctl_en    <= 1'b0;
            r_rcd       <= '0;
            r_mdmask_l  <= 1'b0;
            r_mdmask    <= '0;
            for (int unsigned s = 0; s < NR_MASTERS; s++) begin
                r_srcmd_l[s] <= 1'b0;
                r_srcmd[s]   <= '0;
            end
            for (int unsigned e = 0; e < NR_E; e++) begin
                r_addr[e] <= '0;
                r_cfg[e]  <= '0;
            end
        end else begin
            if (w_wr && (w_off == OFF_CTL) && !r_ctl_l) begin
                r_ctl_l     <= wdata_cfg[31];
                r_ctl_rcall <= wdata_cfg[30];
                r_ctl_en    <= wdata_cfg[0];
            end
            if (w_wr && (w_off == OFF_RCD))
                r_rcd <= '0;
            else if (w_record && (!r_rcd[31] || r_ctl_rcall))
                r_rcd <= {1'b1, 1'b0, access_type_i, 13'b0, w_acc == ACC_READ, 14'(sid_i)};
            if (w_wr && (w_off == OFF_MDMASK) && !r_mdmask_l) begin
                r_mdmask_l <= wdata_cfg[63];
                r_mdmask   <= wdata_cfg[NR_MD-1:0];
            end
            for (int unsigned s = 0; s < NR_MASTERS; s++) begin
                if (w_wr && (w_off == reg_off(32'h100, s, 8)) && !r_srcmd_l[s]) begin
                    r_srcmd_l[s] <= wdata_cfg[63];
                    r_srcmd[s]   <= (r_srcmd[s] & w_frozen) | (wdata_cfg[NR_MD-1:0] & ~w_frozen);
                end
            end
            for (int unsigned e = 0; e < NR_E; e++) begin
                if (w_wr && !r_cfg[e][7]) begin
                    if (w_off == reg_off(32'h400, e, 8))
                        r_addr[e] <= wdata_cfg[IOPMP_LEN-1:0];
                    if (w_off == reg_off(32'h800, e, 1))
                        r_cfg[e] <= wdata_cfg[7:0] & 8'h9F;
                end
            end
        end
    end

    always_comb begin
        rdata_cfg = '0;
        if (w_rd) begin
            if (w_off == OFF_CTL) begin
                rdata_cfg[31] = r_ctl_l;
                rdata_cfg[30] = r_ctl_rcall;
                rdata_cfg[0]  = r_ctl_en;
            end
            if (w_off == OFF_RCD)
                rdata_cfg[31:0] = r_rcd;
            if (w_off == OFF_MDMASK) begin
                rdata_cfg[63]        = r_mdmask_l;
                rdata_cfg[NR_MD-1:0] = r_mdmask;
            end
            for (int unsigned s = 0; s < NR_MASTERS; s++) begin
                if (w_off == reg_off(32'h100, s, 8)) begin
                    rdata_cfg[63]        = r_srcmd_l[s];
                    rdata_cfg[NR_MD-1:0] = r_srcmd[s];
                end
            end
            for (int unsigned e = 0; e < NR_E; e++) begin
                if (w_off == reg_off(32'h400, e, 8))
                    rdata_cfg[IOPMP_LEN-1:0] = r_addr[e];
                if (w_off == reg_off(32'h800, e, 1))
                    rdata_cfg[7:0] = r_cfg[e];
            end
        end
    end

endmodule

// File: tb/tb_io_pmp.sv
// Self-checking bench for io_pmp: directed test plan plus randomized traffic
// compared every cycle against a byte-range behavioural model.
module tb_io_pmp;
    localparam logic [31:0] BASE = 32'h5000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] addr;
    logic        sid;
    logic [1:0]  acc;
    logic [63:0] data;
    logic        allow;
    logic [31:0] acfg;
    logic        en;
    logic        we;
    logic [63:0] wdata;
    logic [63:0] rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    io_pmp #(
        .PLEN(56), .IOPMP_LEN(54), .NR_MD(2), .NR_ENTRIES_PER_MD(8), .NR_MASTERS(2),
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .IOPMP_BASE(32'h5000_0000)
    ) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .sid_i(sid), .access_type_i(acc),
        .data_i(data), .allow_transaction_o(allow), .address_cfg(acfg), .en_cfg(en),
        .we_cfg(we), .wdata_cfg(wdata), .rdata_cfg(rdata)
    );

    // Model state, held as the values a register read would return
    logic [63:0] m_ctl, m_rcd, m_mdmask;
    logic [63:0] m_srcmd [2];
    logic [63:0] m_addr  [16];
    logic [63:0] m_cfg   [16];
    bit          m_valid = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic bit in_range(int e, logic [55:0] ba);
        longint unsigned a, lo, sz, base, b;
        int k;
        b = 64'(ba);
        a = b >> 2;
        case (m_cfg[e][4:3])
            2'd1: begin
                lo = (e == 0) ? 64'd0 : m_addr[(e == 0) ? 0 : e - 1];
                return (a >= lo) && (a < m_addr[e]);
            end
            2'd2: return a == m_addr[e];
            2'd3: begin
                k = 0;
                while (k < 54 && m_addr[e][k]) k++;
                sz   = 64'd1 << (k + 3);
                base = (m_addr[e] << 2) & ~(sz - 1);
                return (b >= base) && (b < base + sz);
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_allow(logic [55:0] ba, int s, int ac);
        if (!m_ctl[0]) return 1'b1;
        if (ac == 0 || s >= 2) return 1'b0;
        for (int e = 0; e < 16; e++) begin
            if (m_srcmd[s][e / 8] && in_range(e, ba)) return m_cfg[e][ac - 1];
        end
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_read(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off == 32'h0)  return m_ctl;
        if (off == 32'h8)  return m_rcd;
        if (off == 32'h10) return m_mdmask;
        if (off >= 32'h100 && off < 32'h110 && off[2:0] == 3'd0) return m_srcmd[int'((off - 32'h100) >> 3)];
        if (off >= 32'h400 && off < 32'h480 && off[2:0] == 3'd0) return m_addr[int'((off - 32'h400) >> 3)];
        if (off >= 32'h800 && off < 32'h810) return m_cfg[int'(off - 32'h800)];
        return 64'd0;
    endfunction

    function automatic void model_write(logic [31:0] a, logic [63:0] d);
        logic [31:0] off;
        logic [1:0]  fr;
        int          i;
        off = a - BASE;
        if (off == 32'h0 && !m_ctl[31]) m_ctl = d & 64'hC000_0001;
        if (off == 32'h8) m_rcd = 64'd0;
        if (off == 32'h10 && !m_mdmask[63]) m_mdmask = d & 64'h8000_0000_0000_0003;
        if (off >= 32'h100 && off < 32'h110 && off[2:0] == 3'd0) begin
            i  = int'((off - 32'h100) >> 3);
            fr = m_mdmask[63] ? m_mdmask[1:0] : 2'b00;
            if (!m_srcmd[i][63])
                m_srcmd[i] = {d[63], 61'd0, (m_srcmd[i][1:0] & fr) | (d[1:0] & ~fr)};
        end
        if (off >= 32'h400 && off < 32'h480 && off[2:0] == 3'd0) begin
            i = int'((off - 32'h400) >> 3);
            if (!m_cfg[i][7]) m_addr[i] = d & ((64'd1 << 54) - 1);
        end
        if (off >= 32'h800 && off < 32'h810) begin
            i = int'(off - 32'h800);
            if (!m_cfg[i][7]) m_cfg[i] = d & 64'h9F;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ctl = 0; m_rcd = 0; m_mdmask = 0;
            for (int i = 0; i < 2; i++) m_srcmd[i] = 0;
            for (int i = 0; i < 16; i++) begin m_addr[i] = 0; m_cfg[i] = 0; end
            m_valid = 1'b1;
        end else if (m_valid) begin
            // Record first so that a same-cycle RCD write clears it afterwards
            if (m_ctl[0] && acc != 2'd0 && !model_allow(addr, int'(sid), int'(acc)) &&
                (!m_rcd[31] || m_ctl[30]))
                m_rcd = {32'd0, 1'b1, 1'b0, acc, 13'd0, acc == 2'd1, 13'd0, sid};
            if (en && we) model_write(acfg, wdata);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("allow", 64'(allow), 64'(model_allow(addr, int'(sid), int'(acc))));
            chk("rdata", rdata, (en && !we) ? model_read(acfg) : 64'd0);
        end
    end

    task automatic setin(logic e, logic w, logic [31:0] a, logic [63:0] d,
                         logic [55:0] ad, logic s, logic [1:0] ac);
        en = e; we = w; acfg = a; wdata = d; addr = ad; sid = s; acc = ac;
        data = {$urandom, $urandom};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [31:0] off, logic [63:0] d);
        setin(1'b1, 1'b1, BASE + off, d, 56'd0, 1'b0, 2'd0);
        step();
    endtask

    task automatic rd_chk(string nm, logic [31:0] off, logic [63:0] exp);
        setin(1'b1, 1'b0, BASE + off, 64'd0, 56'd0, 1'b0, 2'd0);
        #2;
        chk(nm, rdata, exp);
        chk({nm, "_model"}, model_read(BASE + off), exp);
        step();
    endtask

    task automatic tx_chk(string nm, logic [55:0] ad, logic s, logic [1:0] ac, logic exp);
        setin(1'b0, 1'b0, 32'd0, 64'd0, ad, s, ac);
        #2;
        chk(nm, 64'(allow), 64'(exp));
        chk({nm, "_model"}, 64'(model_allow(ad, int'(s), int'(ac))), 64'(exp));
        step();
    endtask

    initial begin
        logic [31:0] off;
        logic [63:0] d;
        int          cls;
        rst = 1'b1;
        setin(1'b0, 1'b0, 32'd0, 64'd0, 56'd0, 1'b0, 2'd0);
        @(posedge clk);
        step();
        rst = 1'b0;

        rd_chk("reset_ctl", 32'h0, 64'd0);
        tx_chk("reset_allow", 56'h4007, 1'b1, 2'd2, 1'b1);

        wr(32'h000, 64'hC000_0001);
        wr(32'h100, 64'h8000_0000_0000_0001);
        wr(32'h108, 64'h8000_0000_0000_0000);
        wr(32'h010, 64'h8000_0000_0000_0001);
        wr(32'h400, 64'h1000); wr(32'h800, 64'h9D);
        wr(32'h408, 64'h2000); wr(32'h801, 64'h9E);
        wr(32'h410, 64'h3000); wr(32'h802, 64'h8E);
        rd_chk("ctl_readback", 32'h0, 64'hC000_0001);
        rd_chk("cfg2_readback", 32'h802, 64'h8E);

        tx_chk("read_sid0", 56'h4007, 1'b0, 2'd1, 1'b1);
        tx_chk("exec_sid0", 56'h4000, 1'b0, 2'd3, 1'b1);
        tx_chk("read_sid1", 56'h4007, 1'b1, 2'd1, 1'b0);
        rd_chk("rcd_read_sid1", 32'h8, 64'h9000_4001);
        tx_chk("write_no_w", 56'h4007, 1'b0, 2'd2, 1'b0);
        rd_chk("rcd_write_sid0", 32'h8, 64'hA000_0000);
        tx_chk("tor_inside", 56'h9400, 1'b0, 2'd2, 1'b1);
        tx_chk("tor_upper_edge", 56'hC000, 1'b0, 2'd2, 1'b0);
        tx_chk("tor_lower_edge", 56'h8000, 1'b0, 2'd2, 1'b1);
        tx_chk("none_denied", 56'h4000, 1'b0, 2'd0, 1'b0);
        wr(32'h008, 64'hFFFF);
        rd_chk("rcd_cleared", 32'h8, 64'd0);

        wr(32'h000, 64'd0);
        rd_chk("ctl_locked", 32'h0, 64'hC000_0001);
        wr(32'h800, 64'd0);
        rd_chk("cfg0_locked", 32'h800, 64'h9D);
        wr(32'h400, 64'h55);
        rd_chk("addr0_locked", 32'h400, 64'h1000);
        rd_chk("unmapped", 32'h104, 64'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        tx_chk("en0_allow", 56'h4007, 1'b1, 2'd2, 1'b1);
        rd_chk("ctl_after_reset", 32'h0, 64'd0);

        // Randomized traffic checked every cycle by the negedge compare process
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            cls = $urandom_range(0, 7);
            d   = {$urandom, $urandom};
            case (cls)
                0: begin off = 32'h0; d[0] = ($urandom_range(0, 3) != 0); end
                1: off = 32'h8;
                2: off = 32'h10;
                3: off = 32'h100 + 32'($urandom_range(0, 1)) * 8;
                4: begin
                    off = 32'h400 + 32'($urandom_range(0, 15)) * 8;
                    case ($urandom_range(0, 7))
                        0: d = '1;
                        1: ;
                        default: d = 64'($urandom_range(0, 72));
                    endcase
                end
                5: off = 32'h800 + 32'($urandom_range(0, 15));
                6: off = 32'($urandom_range(0, 32'hFFF));
                default: off = $urandom - BASE;
            endcase
            if ($urandom_range(0, 15) != 0) begin
                d[63] = 1'b0; d[31] = 1'b0; d[7] = 1'b0;
            end
            setin($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), BASE + off, d,
                  ($urandom_range(0, 7) == 0) ? 56'({$urandom, $urandom}) : 56'($urandom_range(0, 32'h13F)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
